// File: rtl/proc_test_sequencer.sv
// Sequences a processor through a table of test programs: optional processor
// reset, run to the final PC under a sequence-wide watchdog, then check dmemout.
module proc_test_sequencer #(
  parameter int          NUM_PROGS      = 2,
  parameter logic [15:0] WATCHDOG_LIMIT = 16'hFF,
  parameter int          RESET_CYCLES   = 1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  prog_idx,
  input  logic [63:0] prog_start_pc,
  input  logic [63:0] prog_end_pc,
  input  logic [63:0] prog_expected,
  input  logic        prog_reset_en,
  input  logic [63:0] currentpc,
  input  logic [63:0] dmemout,
  output logic        proc_resetl,
  output logic [63:0] proc_startpc,
  output logic        busy,
  output logic        result_valid,
  output logic        result_pass,
  output logic [7:0]  passed,
  output logic        done,
  output logic        all_passed,
  output logic        watchdog_expired,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RSTP   = 3'd2,
    S_RUN    = 3'd3,
    S_SETTLE = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [7:0] LAST_IDX   = 8'(NUM_PROGS - 1);
  localparam logic [7:0] NUM_PROGS8 = 8'(NUM_PROGS);
  localparam logic [7:0] RST_LAST   = 8'(RESET_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  passed_q, passed_d;
  logic [63:0] startpc_q, startpc_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        wd_exp_q, wd_exp_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic        match;

  assign match = (dmemout == prog_expected);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 8'd0;
      passed_q  <= 8'd0;
      startpc_q <= 64'd0;
      wd_cnt_q  <= 16'd0;
      wd_exp_q  <= 1'b0;
      rst_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      passed_q  <= passed_d;
      startpc_q <= startpc_d;
      wd_cnt_q  <= wd_cnt_d;
      wd_exp_q  <= wd_exp_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    passed_d  = passed_q;
    startpc_d = startpc_q;
    wd_cnt_d  = wd_cnt_q;
    wd_exp_d  = wd_exp_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d    = 8'd0;
          passed_d = 8'd0;
          wd_cnt_d = 16'd0;
          wd_exp_d = 1'b0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        startpc_d = prog_start_pc;
        rst_cnt_d = 8'd0;
        state_d   = prog_reset_en ? S_RSTP : S_RUN;
      end
      S_RSTP: begin
        if (rst_cnt_q == RST_LAST) state_d = S_RUN;
        else                       rst_cnt_d = rst_cnt_q + 8'd1;
      end
      S_RUN: begin
        // Reaching the end PC wins over a watchdog expiry in the same cycle.
        if (currentpc >= prog_end_pc) begin
          state_d = S_SETTLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
          if (wd_cnt_q + 16'd1 == WATCHDOG_LIMIT) begin
            wd_exp_d = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_SETTLE: state_d = S_CHECK;
      S_CHECK: begin
        if (match && passed_q != 8'hFF) passed_d = passed_q + 8'd1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded from the state register so a reset releases proc_resetl on the same edge.
  assign proc_resetl      = (state_q != S_RSTP);
  assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
  assign result_valid     = (state_q == S_CHECK);
  assign result_pass      = (state_q == S_CHECK) && match;
  assign done             = (state_q == S_DONE);
  assign all_passed       = (state_q == S_DONE) && (passed_q == NUM_PROGS8) && !wd_exp_q;
  assign prog_idx         = idx_q;
  assign passed           = passed_q;
  assign proc_startpc     = startpc_q;
  assign watchdog_expired = wd_exp_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_proc_test_sequencer.sv
// Bench for proc_test_sequencer: behavioural processor plus program table,
// expected result_pass values queued at start and popped on each result_valid.
module tb_proc_test_sequencer;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  prog_idx;
  logic [63:0] prog_start_pc, prog_end_pc, prog_expected;
  logic        prog_reset_en;
  logic [63:0] currentpc, dmemout;
  logic        proc_resetl;
  logic [63:0] proc_startpc;
  logic        busy, result_valid, result_pass, done, all_passed, watchdog_expired;
  logic [7:0]  passed;
  logic [2:0]  dbg_state;

  logic        start3;
  logic [7:0]  prog_idx3, passed3;
  logic [63:0] currentpc3, proc_startpc3;
  logic        proc_resetl3, busy3, result_valid3, result_pass3, done3, all_passed3, wd3;
  logic [2:0]  dbg_state3;

  int checks   = 0;
  int failures = 0;
  logic exp_q[$];

  logic [63:0] tbl_start [2] = '{64'h0, 64'h0};
  logic [63:0] tbl_end   [2] = '{64'h34, 64'h70};
  logic [63:0] tbl_exp   [2] = '{64'hF, 64'h123456789abcdef0};
  logic        tbl_rst   [2] = '{1'b1, 1'b0};

  logic        pc_freeze = 1'b0;
  logic        corrupt1  = 1'b0;
  logic [63:0] model_pc  = 64'd0;
  logic [63:0] model_pc3 = 64'd0;

  always #5 CLK = ~CLK;

  assign prog_start_pc = tbl_start[prog_idx[0]];
  assign prog_end_pc   = tbl_end[prog_idx[0]];
  assign prog_expected = tbl_exp[prog_idx[0]];
  assign prog_reset_en = tbl_rst[prog_idx[0]];
  assign currentpc     = pc_freeze ? 64'h10 : model_pc;
  assign dmemout       = (corrupt1 && prog_idx == 8'd1) ? 64'd0 : tbl_exp[prog_idx[0]];
  assign currentpc3    = model_pc3;

  always @(posedge CLK) begin
    if (!proc_resetl) model_pc <= proc_startpc;
    else              model_pc <= model_pc + 64'd4;
    if (!proc_resetl3) model_pc3 <= proc_startpc3;
    else               model_pc3 <= model_pc3 + 64'd4;
  end

  proc_test_sequencer dut (
    .CLK(CLK), .reset(reset), .start(start), .prog_idx(prog_idx),
    .prog_start_pc(prog_start_pc), .prog_end_pc(prog_end_pc),
    .prog_expected(prog_expected), .prog_reset_en(prog_reset_en),
    .currentpc(currentpc), .dmemout(dmemout), .proc_resetl(proc_resetl),
    .proc_startpc(proc_startpc), .busy(busy), .result_valid(result_valid),
    .result_pass(result_pass), .passed(passed), .done(done),
    .all_passed(all_passed), .watchdog_expired(watchdog_expired),
    .dbg_state(dbg_state)
  );

  proc_test_sequencer #(.NUM_PROGS(1), .RESET_CYCLES(3)) dut3 (
    .CLK(CLK), .reset(reset), .start(start3), .prog_idx(prog_idx3),
    .prog_start_pc(64'h40), .prog_end_pc(64'h48),
    .prog_expected(64'h55), .prog_reset_en(1'b1),
    .currentpc(currentpc3), .dmemout(64'h55), .proc_resetl(proc_resetl3),
    .proc_startpc(proc_startpc3), .busy(busy3), .result_valid(result_valid3),
    .result_pass(result_pass3), .passed(passed3), .done(done3),
    .all_passed(all_passed3), .watchdog_expired(wd3),
    .dbg_state(dbg_state3)
  );

  // Scoreboard: every result_valid pulse consumes one queued expectation.
  always @(negedge CLK) begin
    if (result_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: result_valid=1 with no expected entry (prog_idx=%0d)", prog_idx);
      end else begin
        logic e;
        e = exp_q.pop_front();
        if (result_pass !== e) begin
          failures++;
          $display("FAIL result_pass: got %b expected %b (prog_idx=%0d)", result_pass, e, prog_idx);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input int cyc_in, output int cyc);
    cyc = cyc_in;
    while (done !== 1'b1 && cyc < 1000) begin
      @(negedge CLK);
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    start3 = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    checks++;
    if ({prog_idx, passed, proc_resetl, busy, result_valid, result_pass, done, all_passed, watchdog_expired}
        !== {8'd0, 8'd0, 1'b1, 6'd0}) begin
      failures++;
      $display("FAIL reset_outputs: idx=%0d passed=%0d resetl=%b busy=%b rv=%b rp=%b done=%b allp=%b wd=%b",
               prog_idx, passed, proc_resetl, busy, result_valid, result_pass, done, all_passed, watchdog_expired);
    end
    checks++;
    if (proc_startpc !== 64'd0) begin
      failures++;
      $display("FAIL reset_startpc: got %0h expected 0", proc_startpc);
    end
  endtask

  task automatic test_all_pass();
    int cyc;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    pulse_start();
    wait_done(1, cyc);
    checks++;
    if (cyc != 34) begin
      failures++;
      $display("FAIL all_pass_cycles: got %0d expected 34", cyc);
    end
    checks++;
    if (passed !== 8'd2 || all_passed !== 1'b1) begin
      failures++;
      $display("FAIL all_pass_result: passed=%0d all_passed=%b expected 2/1", passed, all_passed);
    end
    repeat (5) @(negedge CLK);
    checks++;
    if (done !== 1'b1 || prog_idx !== 8'd1 || passed !== 8'd2 || watchdog_expired !== 1'b0) begin
      failures++;
      $display("FAIL done_hold: done=%b idx=%0d passed=%0d wd=%b expected 1/1/2/0", done, prog_idx, passed, watchdog_expired);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL all_pass_missing: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_mismatch();
    int cyc;
    corrupt1 = 1'b1;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    pulse_start();
    wait_done(1, cyc);
    checks++;
    if (passed !== 8'd1 || done !== 1'b1 || all_passed !== 1'b0) begin
      failures++;
      $display("FAIL mismatch_result: passed=%0d done=%b all_passed=%b expected 1/1/0", passed, done, all_passed);
    end
    corrupt1 = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_start_in_done();
    int cyc;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    pulse_start();
    checks++;
    if (passed !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL restart_clear: passed=%0d busy=%b done=%b expected 0/1/0", passed, busy, done);
    end
    wait_done(1, cyc);
    checks++;
    if (passed !== 8'd2 || all_passed !== 1'b1) begin
      failures++;
      $display("FAIL restart_result: passed=%0d all_passed=%b expected 2/1", passed, all_passed);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    pulse_start();
    repeat (9) @(negedge CLK);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_in_run: got %b expected 1", busy);
    end
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done(11, cyc);
    checks++;
    if (cyc != 34 || passed !== 8'd2 || all_passed !== 1'b1) begin
      failures++;
      $display("FAIL start_ignored: cycles=%0d passed=%0d all_passed=%b expected 34/2/1", cyc, passed, all_passed);
    end
  endtask

  task automatic test_watchdog();
    int cyc;
    pc_freeze = 1'b1;
    pulse_start();
    wait_done(1, cyc);
    checks++;
    if (cyc != 258) begin
      failures++;
      $display("FAIL watchdog_cycles: got %0d expected 258", cyc);
    end
    checks++;
    if (watchdog_expired !== 1'b1 || all_passed !== 1'b0 || passed !== 8'd0 || prog_idx !== 8'd0) begin
      failures++;
      $display("FAIL watchdog_state: wd=%b all_passed=%b passed=%0d idx=%0d expected 1/0/0/0",
               watchdog_expired, all_passed, passed, prog_idx);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (watchdog_expired !== 1'b1 || done !== 1'b1) begin
      failures++;
      $display("FAIL watchdog_sticky: wd=%b done=%b expected 1/1", watchdog_expired, done);
    end
    pc_freeze = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    pulse_start();
    checks++;
    if (watchdog_expired !== 1'b0) begin
      failures++;
      $display("FAIL wd_clear_on_start: got %b expected 0", watchdog_expired);
    end
    repeat (6) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    exp_q.delete();
    checks++;
    if ({prog_idx, passed, proc_resetl, busy, result_valid, result_pass, done, all_passed, watchdog_expired}
        !== {8'd0, 8'd0, 1'b1, 6'd0} || proc_startpc !== 64'd0) begin
      failures++;
      $display("FAIL midrun_reset: idx=%0d passed=%0d resetl=%b busy=%b done=%b wd=%b startpc=%0h expected idle values",
               prog_idx, passed, proc_resetl, busy, done, watchdog_expired, proc_startpc);
    end
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    pulse_start();
    checks++;
    if (prog_idx !== 8'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rerun_start: idx=%0d busy=%b expected 0/1", prog_idx, busy);
    end
    wait_done(1, cyc);
    checks++;
    if (cyc != 34 || passed !== 8'd2 || all_passed !== 1'b1) begin
      failures++;
      $display("FAIL rerun_result: cycles=%0d passed=%0d all_passed=%b expected 34/2/1", cyc, passed, all_passed);
    end
  endtask

  task automatic test_reset_in_rstp();
    pulse_start();
    @(negedge CLK);
    checks++;
    if (proc_resetl !== 1'b0) begin
      failures++;
      $display("FAIL rstp_low: proc_resetl=%b expected 0", proc_resetl);
    end
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    checks++;
    if (proc_resetl !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstp_release: proc_resetl=%b busy=%b expected 1/0", proc_resetl, busy);
    end
  endtask

  task automatic test_reset_cycles();
    int lows = 0;
    int pulses = 0;
    int cyc = 0;
    start3 = 1'b1;
    @(negedge CLK);
    start3 = 1'b0;
    while (done3 !== 1'b1 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (proc_resetl3 === 1'b0) lows++;
      if (result_valid3 === 1'b1) pulses++;
    end
    checks++;
    if (lows != 3) begin
      failures++;
      $display("FAIL reset_cycles3: proc_resetl low %0d cycles, expected 3", lows);
    end
    checks++;
    if (proc_startpc3 !== 64'h40) begin
      failures++;
      $display("FAIL startpc3: got %0h expected 40", proc_startpc3);
    end
    checks++;
    if (done3 !== 1'b1 || all_passed3 !== 1'b1 || pulses != 1) begin
      failures++;
      $display("FAIL dut3_result: done=%b all_passed=%b pulses=%0d expected 1/1/1", done3, all_passed3, pulses);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    start3 = 1'b0;
    @(negedge CLK);
    test_reset();
    test_all_pass();
    test_mismatch();
    test_start_in_done();
    test_start_ignored();
    test_watchdog();
    test_reset_mid_run();
    test_reset_in_rstp();
    test_reset_cycles();
    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/proc_test_sequencer.md
PROC_TEST_SEQUENCER -- requirements
Module: proc_test_sequencer

Interface
REQ-001 Parameter NUM_PROGS, default 2: number of program table entries to run.
REQ-002 Parameter WATCHDOG_LIMIT, default 16'hFF: total RUN cycles allowed per sequence.
REQ-003 Parameter RESET_CYCLES, default 1: cycles proc_resetl is held low per processor reset.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  launches a test sequence; sampled in IDLE and DONE only.
REQ-007 prog_idx  out  8  index into the external combinational program table.
REQ-008 prog_start_pc  in  64  table entry start PC.
REQ-009 prog_end_pc  in  64  table entry final-instruction PC.
REQ-010 prog_expected  in  64  table entry expected dmemout value.
REQ-011 prog_reset_en  in  1  1 = reset the processor before this entry; 0 = continue from current state.
REQ-012 currentpc  in  64  processor PC.
REQ-013 dmemout  in  64  processor data-memory read output.
REQ-014 proc_resetl  out  1  active-low processor reset.
REQ-015 proc_startpc  out  64  processor start PC.
REQ-016 busy  out  1  high in every state except IDLE and DONE.
REQ-017 result_valid  out  1  one-cycle pulse per checked entry.
REQ-018 result_pass  out  1  compare result, valid with result_valid.
REQ-019 passed  out  8  count of passing entries in the current sequence.
REQ-020 done  out  1  high in DONE.
REQ-021 all_passed  out  1  high in DONE iff passed == NUM_PROGS and no watchdog expiry.
REQ-022 watchdog_expired  out  1  sticky until next start or reset.

Function
REQ-023 States SHALL be IDLE, LOAD, RSTP, RUN, SETTLE, CHECK, DONE.
REQ-024 IDLE/DONE + start=1: prog_idx<=0, passed<=0, watchdog counter<=0, watchdog_expired<=0, -> LOAD.
REQ-025 LOAD (1 cycle): proc_startpc<=prog_start_pc; -> RSTP if prog_reset_en=1, else -> RUN.
REQ-026 RSTP: proc_resetl=0 for exactly RESET_CYCLES cycles, then -> RUN; proc_resetl=1 in all other states.
REQ-027 RUN: if currentpc >= prog_end_pc (unsigned 64-bit) -> SETTLE; else increment watchdog counter (16-bit).
REQ-028 RUN, counter reaching WATCHDOG_LIMIT -> DONE with watchdog_expired=1; end-PC match in the same cycle takes priority over expiry.
REQ-029 SETTLE: exactly 1 cycle for the data-memory read to settle, then -> CHECK.
REQ-030 CHECK: result_valid=1, result_pass=(dmemout==prog_expected); passed increments on a match and saturates at 255.
REQ-031 CHECK exit: prog_idx==NUM_PROGS-1 -> DONE; otherwise prog_idx increments, -> LOAD.
REQ-032 Watchdog counter SHALL NOT be cleared between entries; it spans the whole sequence.
REQ-033 start asserted while busy SHALL be ignored.
REQ-034 DONE SHALL hold prog_idx, passed and watchdog_expired stable until start or reset.

Reset
REQ-035 On reset=1 at a rising edge, regardless of state: state=IDLE, prog_idx=0, passed=0, proc_resetl=1, proc_startpc=0, result_valid=0, result_pass=0, done=0, all_passed=0, watchdog_expired=0, watchdog counter=0.
REQ-036 Reset during RSTP SHALL release proc_resetl to 1 on the same edge.

Verification
REQ-037 Table {0: start 0, end 0x34, exp 0xF, rst 1; 1: end 0x70, exp 0x123456789abcdef0, rst 0}, correct processor model -> two result_valid pulses with result_pass=1, passed=2, all_passed=1.
REQ-038 Same table, entry 1 dmemout returns 0x0 -> second result_pass=0, passed=1, done=1, all_passed=0.
REQ-039 currentpc frozen at 0x10 -> watchdog_expired=1 and DONE after exactly 255 RUN cycles, no result_valid.
REQ-040 RESET_CYCLES=3, entry 0 rst=1, start PC 0x40 -> proc_resetl low exactly 3 cycles, proc_startpc=0x40.
REQ-041 reset asserted mid-RUN -> next cycle IDLE, all outputs at REQ-035 values; subsequent start reruns from prog_idx=0.
REQ-042 start pulsed during RUN -> ignored, sequence completes unchanged; start in DONE -> new sequence, passed cleared.
